// File: rtl/dac_spi_serializer.sv
// Serialises one {CTRL, sample} word per accepted start into a 16-bit SPI DAC frame.
// SCK idles high, the DAC samples MOSI on the falling edge, and CS stays high for 2*CLK_DIV cycles after each frame.
module dac_spi_serializer #(
  parameter int                             DATA_BIT  = 12,
  parameter int                             FRAME_BIT = 16,
  parameter logic [FRAME_BIT-DATA_BIT-1:0]  CTRL      = '0,
  parameter int                             CLK_DIV   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_BIT-1:0] value_in,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                dropped,
  output logic                spi_mosi,
  output logic                spi_sck,
  output logic                spi_cs,
  output logic [1:0]          state_dbg
);

  localparam int HW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(FRAME_BIT + 1);
  localparam logic [HW-1:0] DIV_LOAD = HW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LOAD = BW'(FRAME_BIT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t                 state, state_n;
  logic                   phase, phase_n;
  logic [HW-1:0]          half_cnt, half_cnt_n;
  logic [BW-1:0]          bit_cnt, bit_cnt_n;
  logic [FRAME_BIT-2:0]   shreg, shreg_n;
  logic                   cs_n, sck_n, mosi_n, busy_n, done_n;
  logic [FRAME_BIT-1:0]   frame_word;

  assign frame_word = {CTRL, value_in};
  assign state_dbg  = state;

  // Handshake: start is accepted only while busy is low; a start while busy is
  // answered with dropped in the same cycle and otherwise ignored (never queued).
  assign dropped = start & busy;

  always_comb begin
    state_n    = state;
    phase_n    = phase;
    half_cnt_n = half_cnt;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    cs_n       = spi_cs;
    sck_n      = spi_sck;
    mosi_n     = spi_mosi;
    busy_n     = busy;
    done_n     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n    = SETUP;
          phase_n    = 1'b0;
          half_cnt_n = DIV_LOAD;
          bit_cnt_n  = BIT_LOAD;
          shreg_n    = frame_word[FRAME_BIT-2:0];
          cs_n       = 1'b0;
          sck_n      = 1'b1;
          mosi_n     = frame_word[FRAME_BIT-1];
          busy_n     = 1'b1;
        end
      end
      SETUP: begin
        if (half_cnt != '0) begin
          half_cnt_n = half_cnt - 1'b1;
        end else begin
          state_n    = SHIFT;
          phase_n    = 1'b0;
          half_cnt_n = DIV_LOAD;
          sck_n      = 1'b0;
        end
      end
      SHIFT: begin
        if (half_cnt != '0) begin
          half_cnt_n = half_cnt - 1'b1;
        end else if (!phase) begin
          // Rising SCK edge: MOSI moves to the next bit, leaving a full half-period of setup.
          phase_n    = 1'b1;
          half_cnt_n = DIV_LOAD;
          sck_n      = 1'b1;
          mosi_n     = shreg[FRAME_BIT-2];
          shreg_n    = shreg << 1;
        end else if (bit_cnt == '0) begin
          state_n    = HOLD;
          phase_n    = 1'b0;
          half_cnt_n = DIV_LOAD;
          cs_n       = 1'b1;
          mosi_n     = 1'b0;
        end else begin
          phase_n    = 1'b0;
          half_cnt_n = DIV_LOAD;
          bit_cnt_n  = bit_cnt - 1'b1;
          sck_n      = 1'b0;
        end
      end
      HOLD: begin
        // Two CLK_DIV-long halves keep the counter within $clog2(CLK_DIV+1) bits.
        if (half_cnt != '0) begin
          half_cnt_n = half_cnt - 1'b1;
        end else if (!phase) begin
          phase_n    = 1'b1;
          half_cnt_n = DIV_LOAD;
        end else begin
          state_n    = IDLE;
          phase_n    = 1'b0;
          half_cnt_n = '0;
          busy_n     = 1'b0;
          done_n     = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      phase    <= 1'b0;
      half_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      spi_cs   <= 1'b1;
      spi_sck  <= 1'b1;
      spi_mosi <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      half_cnt <= half_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      spi_cs   <= cs_n;
      spi_sck  <= sck_n;
      spi_mosi <= mosi_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_dac_spi_serializer.sv
// Bench for dac_spi_serializer: two instances (CLK_DIV 1 and 3) share stimulus and are
// compared every cycle against a time-since-accept model plus an SPI frame monitor.
module tb_dac_spi_serializer;

  localparam int D0 = 1;
  localparam int D1 = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [11:0] value_in;
  logic        start;
  logic        busy_o[2], done_o[2], dropped_o[2], mosi_o[2], sck_o[2], cs_o[2];
  logic [1:0]  st_o[2];

  dac_spi_serializer #(.CLK_DIV(D0)) dut_d1 (
    .clk(clk), .rst(rst), .value_in(value_in), .start(start),
    .busy(busy_o[0]), .done(done_o[0]), .dropped(dropped_o[0]),
    .spi_mosi(mosi_o[0]), .spi_sck(sck_o[0]), .spi_cs(cs_o[0]), .state_dbg(st_o[0])
  );

  dac_spi_serializer #(.CLK_DIV(D1)) dut_d3 (
    .clk(clk), .rst(rst), .value_in(value_in), .start(start),
    .busy(busy_o[1]), .done(done_o[1]), .dropped(dropped_o[1]),
    .spi_mosi(mosi_o[1]), .spi_sck(sck_o[1]), .spi_cs(cs_o[1]), .state_dbg(st_o[1])
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  bit          act[2];
  int          t[2];
  logic [15:0] frm[2];
  bit          done_m[2];

  function automatic int div_of(input int i);
    return (i == 0) ? D0 : D1;
  endfunction

  // Expected {cs, sck, mosi, busy} from the cycle index t since acceptance.
  function automatic logic [3:0] model_pins(input int d, input bit a, input int tt,
                                            input logic [15:0] f);
    int u, k, idx;
    bit hi;
    if (!a) return 4'b1100;
    if (tt < d) return {1'b0, 1'b1, f[15], 1'b1};
    if (tt < d + 32 * d) begin
      u   = tt - d;
      k   = u / (2 * d);
      hi  = (u % (2 * d)) >= d;
      idx = 14 - k;
      if (!hi) return {1'b0, 1'b0, f[15-k], 1'b1};
      return {1'b0, 1'b1, (idx < 0) ? 1'b0 : f[idx], 1'b1};
    end
    return 4'b1101;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (act[i]) begin
          if (i == 0) exp_q0.delete(exp_q0.size() - 1);
          else        exp_q1.delete(exp_q1.size() - 1);
        end
        act[i]    = 1'b0;
        t[i]      = 0;
        done_m[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        done_m[i] = 1'b0;
        if (act[i]) begin
          t[i]++;
          if (t[i] == 35 * div_of(i)) begin
            act[i]    = 1'b0;
            done_m[i] = 1'b1;
          end
        end else if (start) begin
          act[i] = 1'b1;
          t[i]   = 0;
          frm[i] = {4'h0, value_in};
          if (i == 0) exp_q0.push_back(frm[i]);
          else        exp_q1.push_back(frm[i]);
        end
      end
    end
  end

  // ---------------- per-cycle pin check and SPI monitor ----------------
  logic [15:0] cap[2];
  int          nb[2];
  logic        prev_sck[2], prev_cs[2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check(i == 0 ? "pins_d1" : "pins_d3",
            {cs_o[i], sck_o[i], mosi_o[i], busy_o[i], done_o[i], dropped_o[i]},
            {model_pins(div_of(i), act[i], t[i], frm[i]), done_m[i], start & act[i]});
      if (!rst) begin
        cap[i] = '0; nb[i] = 0; prev_sck[i] = 1'b1; prev_cs[i] = 1'b1;
      end else begin
        if (!cs_o[i] && prev_sck[i] && !sck_o[i]) begin
          cap[i] = {cap[i][14:0], mosi_o[i]};
          nb[i]++;
        end
        if (!prev_cs[i] && cs_o[i]) begin
          check(i == 0 ? "frame_bits_d1" : "frame_bits_d3", nb[i], 16);
          if (i == 0 && exp_q0.size() > 0)      check("frame_d1", cap[i], exp_q0.pop_front());
          else if (i == 1 && exp_q1.size() > 0) check("frame_d3", cap[i], exp_q1.pop_front());
          else check(i == 0 ? "frame_extra_d1" : "frame_extra_d3", cap[i], 32'hFFFF_FFFF);
          cap[i] = '0; nb[i] = 0;
        end
        prev_sck[i] = sck_o[i];
        prev_cs[i]  = cs_o[i];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [11:0] v);
    value_in = v;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_o[0] || busy_o[1]) && n < 400) begin
      step();
      n++;
    end
    check("idle_timeout", {31'b0, busy_o[0] | busy_o[1]}, 0);
    step();
  endtask

  task automatic check_reset_pins(input string tag);
    for (int i = 0; i < 2; i++) begin
      check(tag, {cs_o[i], sck_o[i], mosi_o[i], busy_o[i], done_o[i], dropped_o[i]}, 6'b110000);
      check("state_dbg", {30'b0, st_o[i]}, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst      = 1'b0;
    start    = 1'b0;
    value_in = '0;
    repeat (3) step();
    check_reset_pins("reset_pins");
    rst = 1'b1;
    step();

    // basic frame
    send(12'hABC);
    wait_idle();

    // data boundaries, second start in the done cycle of the fast instance
    send(12'h000);
    n = 0;
    while (!done_o[0] && n < 100) begin
      step();
      n++;
    end
    check("done_seen", {31'b0, done_o[0]}, 1);
    send(12'hFFF);
    wait_idle();

    // overrun: second start at cycle 10 of a frame with a changed value
    send(12'h123);
    repeat (9) step();
    send(12'h456);
    wait_idle();

    // reset during bit 7 of the fast instance
    send(12'h777);
    repeat (15) step();
    rst = 1'b0;
    #1;
    check_reset_pins("midframe_reset");
    repeat (2) step();
    rst = 1'b1;
    step();
    send(12'h321);
    wait_idle();

    // level start for 100 cycles
    value_in = 12'h5A5;
    start    = 1'b1;
    repeat (100) step();
    start    = 1'b0;
    wait_idle();

    // randomized pulses, holds and gaps
    for (int r = 0; r < 15; r++) begin
      value_in = 12'($urandom_range(0, 4095));
      start    = 1'b1;
      repeat ($urandom_range(1, 3)) step();
      start    = 1'b0;
      repeat ($urandom_range(0, 40)) step();
      value_in = 12'($urandom_range(0, 4095));
    end
    wait_idle();

    check("leftover_q_d1", exp_q0.size(), 0);
    check("leftover_q_d3", exp_q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
